mtsp_trd_scheduler: RTL and testbench
=====================================

MTSP_TRD_SCHEDULER -- requirements
Module: mtsp_trd_scheduler

Interface
REQ-001 SHALL have parameter TRD_COUNT, default 4, number of hardware threads (legal range 2..16).
REQ-002 SHALL have parameter PC_WIDTH, default 16, program counter width.
REQ-003 SHALL have parameter WB_DELAY, default 3, cycles from issue to PC writeback (legal range 1..TRD_COUNT-1).
REQ-004 SHALL have ports: CLK in 1, clock; one clock only, all logic on rising edge.
REQ-005 SHALL have RST in 1, synchronous active-high reset.
REQ-006 SHALL have START in 1, pulse that launches all threads; START_PC in PC_WIDTH, launch PC.
REQ-007 SHALL have PC_nEN in 1 (active-low writeback valid), PC_BOP in 2 (branch op), PC_NEXT in PC_WIDTH (written-back PC).
REQ-008 SHALL have PC_nAWAKE in TRD_COUNT, per-thread active-low wake from memory.
REQ-009 SHALL have SYNC_ACK in 1, multi-core sync release pulse.
REQ-010 SHALL have nTRD out TRD_COUNT (one-hot active-low slot), TRD_nEN out 1 (issue valid, active-low), TRD_PC out PC_WIDTH.
REQ-011 SHALL have SYNC_EN out 1 (sync request pulse), TRD_BUSY out 1 (any thread not IDLE).

Function
REQ-012 SHALL keep a slot counter 0..TRD_COUNT-1 that increments every cycle and wraps from TRD_COUNT-1 to 0.
REQ-013 SHALL register nTRD = ~(1<<slot), TRD_PC = PC[slot], TRD_nEN = 0 only if thread[slot] is RUN; all three update every cycle.
REQ-014 SHALL keep per-thread state: IDLE, RUN, WAIT, SYNC.
REQ-015 SHALL, on START while TRD_BUSY=0, set every PC to START_PC and every state to RUN; START while TRD_BUSY=1 is ignored.
REQ-016 SHALL apply writeback when PC_nEN=0 to the thread whose slot appeared on nTRD exactly WB_DELAY cycles earlier.
REQ-017 SHALL decode PC_BOP: 0 NEXT (PC<=PC_NEXT, stay RUN), 1 WAIT (PC<=PC_NEXT, RUN->WAIT), 2 SYNC (PC<=PC_NEXT, RUN->SYNC), 3 HALT (PC unchanged, ->IDLE).
REQ-018 SHALL ignore writeback addressed to a thread not in RUN.
REQ-019 SHALL move a thread WAIT->RUN in the cycle after PC_nAWAKE[i]=0.
REQ-020 SHALL, if WAIT writeback and PC_nAWAKE[i]=0 hit thread i in the same cycle, leave thread i in RUN (wake not lost).
REQ-021 SHALL pulse SYNC_EN high for one cycle, the cycle after any SYNC writeback is accepted.
REQ-022 SHALL, on SYNC_ACK=1, move every thread already in SYNC to RUN next cycle; a thread entering SYNC in the same cycle stays in SYNC.
REQ-023 SHALL not hold a PC writeback when PC_nEN=1; a RUN thread without writeback re-issues its unchanged PC on its next slot.
REQ-024 SHALL drive TRD_BUSY combinationally as OR of (state != IDLE) over all threads.
REQ-025 SHALL use slot arithmetic modulo TRD_COUNT for the writeback index (slot - WB_DELAY wraps below 0).

Reset
REQ-026 SHALL, on RST=1 at a clock edge, set slot=0, all states IDLE, all PCs 0, nTRD all ones, TRD_nEN=1, TRD_PC=0, SYNC_EN=0, and clear the writeback slot pipeline.
REQ-027 SHALL give RST priority over START, writeback, wake and SYNC_ACK in the same cycle, including mid-operation.
REQ-028 SHALL, in the first cycle after reset release, present nTRD=~1 with TRD_nEN=1.

Verification
REQ-029 Reset then START, START_PC=0x100 (TRD_COUNT=4) -> nTRD cycles 1110,1101,1011,0111, TRD_nEN=0, TRD_PC=0x100 each slot, TRD_BUSY=1.
REQ-030 Writeback NEXT, PC_NEXT=0x104, 3 cycles after thread 2 issues -> thread 2 next issue shows TRD_PC=0x104; others stay 0x100.
REQ-031 WAIT writeback on thread 1, PC_NEXT=0x200 -> thread 1 slot shows TRD_nEN=1; PC_nAWAKE=1101 -> next thread-1 slot TRD_nEN=0, TRD_PC=0x200.
REQ-032 SYNC writeback on threads 0 and 3 -> SYNC_EN one-cycle pulse each; SYNC_ACK -> both resume; SYNC_ACK coincident with thread-3 entry -> thread 3 stays SYNC.
REQ-033 HALT on all four threads -> TRD_BUSY=0 after last; START with 0x300 then relaunches; START while busy -> no PC change.
REQ-034 RST asserted mid-run with WAIT/SYNC threads pending -> all outputs at reset values next cycle, stale writeback after release ignored.

Source files
------------

// File: rtl/mtsp_trd_scheduler.sv
// Barrel-style hardware-thread scheduler: round-robin slot issue with per-thread PC/state.
// Latency: issue outputs registered (1 cycle); PC writeback lands WB_DELAY cycles after a slot is shown.
// Backpressure: none; the slot advances every cycle, and a writeback without PC_nEN=0 is simply dropped.
module mtsp_trd_scheduler #(
  parameter int TRD_COUNT = 4,
  parameter int PC_WIDTH  = 16,
  parameter int WB_DELAY  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [PC_WIDTH-1:0]  START_PC,
  input  logic                 PC_nEN,
  input  logic [1:0]           PC_BOP,
  input  logic [PC_WIDTH-1:0]  PC_NEXT,
  input  logic [TRD_COUNT-1:0] PC_nAWAKE,
  input  logic                 SYNC_ACK,
  output logic [TRD_COUNT-1:0] nTRD,
  output logic                 TRD_nEN,
  output logic [PC_WIDTH-1:0]  TRD_PC,
  output logic                 SYNC_EN,
  output logic                 TRD_BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_SYNC} trd_state_e;

  localparam int SW = (TRD_COUNT > 1) ? $clog2(TRD_COUNT) : 1;

  logic [SW-1:0]       slot;
  trd_state_e          st_q [TRD_COUNT];
  trd_state_e          st_d [TRD_COUNT];
  logic [PC_WIDTH-1:0] pc_q [TRD_COUNT];
  logic [PC_WIDTH-1:0] pc_d [TRD_COUNT];
  logic                sync_hit;

  // History of the slot shown on nTRD: entry 0 is the one shown now, entry j was shown j cycles ago.
  logic [SW-1:0]       wb_idx [WB_DELAY+1];
  logic                wb_vld [WB_DELAY+1];

  always_comb begin
    TRD_BUSY = 1'b0;
    for (int i = 0; i < TRD_COUNT; i++) begin
      TRD_BUSY = TRD_BUSY | (st_q[i] != ST_IDLE);
    end
  end

  always_comb begin
    sync_hit = 1'b0;
    for (int i = 0; i < TRD_COUNT; i++) begin
      st_d[i] = st_q[i];
      pc_d[i] = pc_q[i];
    end
    if (START && !TRD_BUSY) begin
      for (int i = 0; i < TRD_COUNT; i++) begin
        st_d[i] = ST_RUN;
        pc_d[i] = START_PC;
      end
    end else begin
      for (int i = 0; i < TRD_COUNT; i++) begin
        // Only threads already parked in SYNC are released; new entrants wait for the next ack.
        if (SYNC_ACK && st_q[i] == ST_SYNC) st_d[i] = ST_RUN;
        if (!PC_nEN && wb_vld[WB_DELAY] && wb_idx[WB_DELAY] == SW'(i) && st_q[i] == ST_RUN) begin
          case (PC_BOP)
            2'd0: pc_d[i] = PC_NEXT;
            2'd1: begin pc_d[i] = PC_NEXT; st_d[i] = ST_WAIT; end
            2'd2: begin pc_d[i] = PC_NEXT; st_d[i] = ST_SYNC; sync_hit = 1'b1; end
            default: st_d[i] = ST_IDLE;
          endcase
        end
        // Wake also covers a thread entering WAIT this very cycle so the wake is not lost.
        if (st_d[i] == ST_WAIT && !PC_nAWAKE[i]) st_d[i] = ST_RUN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot    <= '0;
      nTRD    <= '1;
      TRD_nEN <= 1'b1;
      TRD_PC  <= '0;
      SYNC_EN <= 1'b0;
      for (int i = 0; i < TRD_COUNT; i++) begin
        st_q[i] <= ST_IDLE;
        pc_q[i] <= '0;
      end
      for (int j = 0; j <= WB_DELAY; j++) begin
        wb_idx[j] <= '0;
        wb_vld[j] <= 1'b0;
      end
    end else begin
      slot    <= (slot == SW'(TRD_COUNT-1)) ? '0 : slot + SW'(1);
      nTRD    <= ~(TRD_COUNT'(1) << slot);
      // Issue from next-state values so a writeback landing on this slot's edge is forwarded.
      TRD_nEN <= (st_d[slot] != ST_RUN);
      TRD_PC  <= pc_d[slot];
      SYNC_EN <= sync_hit;
      for (int i = 0; i < TRD_COUNT; i++) begin
        st_q[i] <= st_d[i];
        pc_q[i] <= pc_d[i];
      end
      wb_idx[0] <= slot;
      wb_vld[0] <= 1'b1;
      for (int j = 1; j <= WB_DELAY; j++) begin
        wb_idx[j] <= wb_idx[j-1];
        wb_vld[j] <= wb_vld[j-1];
      end
    end
  end

endmodule

// File: tb/tb_mtsp_trd_scheduler.sv
// Bench for mtsp_trd_scheduler: directed scenarios plus random traffic against a cycle-count based model.
module tb_mtsp_trd_scheduler;
  localparam int N   = 4;
  localparam int PCW = 16;
  localparam int D   = 3;

  logic           CLK = 1'b0;
  logic           RST, START, PC_nEN, SYNC_ACK;
  logic [PCW-1:0] START_PC, PC_NEXT, TRD_PC;
  logic [1:0]     PC_BOP;
  logic [N-1:0]   PC_nAWAKE, nTRD;
  logic           TRD_nEN, SYNC_EN, TRD_BUSY;

  always #5 CLK = ~CLK;

  mtsp_trd_scheduler #(.TRD_COUNT(N), .PC_WIDTH(PCW), .WB_DELAY(D)) dut (
    .CLK(CLK), .RST(RST), .START(START), .START_PC(START_PC),
    .PC_nEN(PC_nEN), .PC_BOP(PC_BOP), .PC_NEXT(PC_NEXT), .PC_nAWAKE(PC_nAWAKE),
    .SYNC_ACK(SYNC_ACK), .nTRD(nTRD), .TRD_nEN(TRD_nEN), .TRD_PC(TRD_PC),
    .SYNC_EN(SYNC_EN), .TRD_BUSY(TRD_BUSY)
  );

  int checks = 0;
  int failures = 0;

  // Model: states 0=idle 1=run 2=wait 3=sync; cyc counts cycles since the reset edge.
  int m_st [N];
  int m_pc [N];
  int cyc = 0;
  bit m_sync = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_busy();
    bit b = 0;
    for (int i = 0; i < N; i++) if (m_st[i] != 0) b = 1;
    return b;
  endfunction

  // Thread addressed by a writeback presented in the current cycle, or -1 if none yet.
  function automatic int wb_target();
    return (cyc - D >= 1) ? (cyc - D - 1) % N : -1;
  endfunction

  task automatic tick();
    int nst [N];
    int npc [N];
    int tgt, s;
    logic [N-1:0] en;
    if (RST) begin
      for (int i = 0; i < N; i++) begin m_st[i] = 0; m_pc[i] = 0; end
      cyc = 0;
      m_sync = 0;
    end else begin
      nst = m_st;
      npc = m_pc;
      m_sync = 0;
      tgt = wb_target();
      if (START && !m_busy()) begin
        for (int i = 0; i < N; i++) begin nst[i] = 1; npc[i] = int'(START_PC); end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (SYNC_ACK && m_st[i] == 3) nst[i] = 1;
          if (i == tgt && !PC_nEN && m_st[i] == 1) begin
            case (PC_BOP)
              2'd0: npc[i] = int'(PC_NEXT);
              2'd1: begin npc[i] = int'(PC_NEXT); nst[i] = 2; end
              2'd2: begin npc[i] = int'(PC_NEXT); nst[i] = 3; m_sync = 1; end
              default: nst[i] = 0;
            endcase
          end
          if (nst[i] == 2 && !PC_nAWAKE[i]) nst[i] = 1;
        end
      end
      m_st = nst;
      m_pc = npc;
      cyc++;
    end
    @(posedge CLK);
    #1;
    if (cyc == 0) begin
      check("ntrd", 32'(nTRD), 32'(4'hF));
      check("nen", 32'(TRD_nEN), 32'd1);
      check("pc", 32'(TRD_PC), 32'd0);
    end else begin
      s = (cyc - 1) % N;
      en = '1;
      en[s] = 1'b0;
      check("ntrd", 32'(nTRD), 32'(en));
      check("nen", 32'(TRD_nEN), (m_st[s] == 1) ? 32'd0 : 32'd1);
      check("pc", 32'(TRD_PC), 32'(m_pc[s]));
    end
    check("sync_en", 32'(SYNC_EN), 32'(m_sync));
    check("busy", 32'(TRD_BUSY), 32'(m_busy()));
  endtask

  task automatic drive_idle();
    RST = 0; START = 0; START_PC = '0; PC_nEN = 1; PC_BOP = '0;
    PC_NEXT = '0; PC_nAWAKE = '1; SYNC_ACK = 0;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin drive_idle(); tick(); end
  endtask

  // Wait until a writeback would address thread t, then present it for one cycle.
  task automatic wb(int t, int bop, int pcn, logic [N-1:0] awk, bit ack);
    int k = 0;
    while (wb_target() != t) begin
      drive_idle();
      tick();
      k++;
      if (k > 4 * (N + D)) begin
        checks++;
        failures++;
        $display("FAIL wb_timeout thread=%0d", t);
        return;
      end
    end
    PC_nEN = 0; PC_BOP = 2'(bop); PC_NEXT = PCW'(pcn); PC_nAWAKE = awk; SYNC_ACK = ack;
    tick();
    drive_idle();
  endtask

  initial begin
    drive_idle();
    RST = 1;
    tick();
    tick();
    idle(1);
    START = 1; START_PC = 16'h0100;
    tick();
    idle(4);
    wb(2, 0, 'h104, '1, 0);
    idle(4);
    wb(1, 1, 'h200, '1, 0);
    idle(4);
    PC_nAWAKE = 4'b1101;
    tick();
    idle(4);
    wb(0, 2, 'h300, '1, 0);
    idle(2);
    wb(3, 2, 'h310, '1, 0);
    idle(2);
    SYNC_ACK = 1;
    tick();
    idle(2);
    wb(0, 2, 'h320, '1, 0);
    wb(3, 2, 'h330, '1, 1);
    idle(4);
    SYNC_ACK = 1;
    tick();
    idle(2);
    wb(1, 1, 'h220, 4'b1101, 0);
    idle(4);
    START = 1; START_PC = 16'h0777;
    tick();
    idle(2);
    for (int t = 0; t < N; t++) wb(t, 3, 0, '1, 0);
    idle(4);
    START = 1; START_PC = 16'h0300;
    tick();
    idle(4);
    wb(1, 1, 'h400, '1, 0);
    wb(2, 2, 'h410, '1, 0);
    RST = 1;
    tick();
    drive_idle();
    for (int k = 0; k < 2 * N; k++) begin
      PC_nEN = 0; PC_BOP = 2'(k % 4); PC_NEXT = 16'h0bad;
      tick();
    end
    drive_idle();

    for (int k = 0; k < 3000; k++) begin
      int r;
      drive_idle();
      RST = ($urandom_range(0, 199) == 0);
      START = ($urandom_range(0, 19) == 0);
      START_PC = PCW'($urandom);
      PC_nEN = ($urandom_range(0, 9) < 4);
      r = $urandom_range(0, 9);
      PC_BOP = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      PC_NEXT = PCW'($urandom);
      for (int i = 0; i < N; i++) PC_nAWAKE[i] = ($urandom_range(0, 3) != 0);
      SYNC_ACK = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
